ppu_pixel_out: RTL
==================

# ppu_pixel_out

Final pixel stage of the PPU, directly downstream of the background and sprite sub-blocks. Each NES dot, it combines the 4-bit background palette index with the 4-bit sprite palette index using NES priority rules. It looks the result up in the 32-entry palette RAM and registers a 6-bit system palette index for the video output stage. It also owns the CPU-visible palette RAM port ($3F00-$3F1F) and the sticky sprite-0 hit flag ($2002.6).

## Interface
Parameters: none.

Clocking and reset: one clock; reset is synchronous and active-high.

- clk_in  in  1  50MHz system clock
- rst_in  in  1  synchronous, active-high reset
- nes_x_in  in  10  current nes x coordinate (0-340)
- nes_y_in  in  10  current nes y coordinate (0-261; 261 = pre-render)
- pix_pulse_in  in  1  one-clock pulse immediately before nes x changes
- bg_palette_idx_in  in  4  background palette index, {attr[1:0], pattern[1:0]}; 0 when disabled or clipped
- spr_palette_idx_in  in  4  sprite palette index, same encoding
- spr_primary_in  in  1  current sprite pixel comes from OAM sprite 0
- spr_priority_in  in  1  1 = sprite sits behind background
- pal_a_in  in  5  palette RAM address from the register interface
- pal_d_in  in  6  palette write data
- pal_wr_in  in  1  palette write strobe, one clock
- pal_d_out  out  6  palette read data at pal_a_in (combinational)
- spr0_hit_out  out  1  sticky sprite-0 hit flag
- sys_palette_idx_out  out  6  registered system palette index of the last sampled pixel

## Operation

**Palette RAM**
- 32 x 6-bit.
- Addresses 0x10, 0x14, 0x18 and 0x1C alias 0x00, 0x04, 0x08 and 0x0C for both read and write. Mirroring is applied to pal_a_in and to the render lookup.
- Write: on a clock with pal_wr_in=1, entry mirror(pal_a_in) is set to pal_d_in.
- pal_d_out = entry mirror(pal_a_in), combinational.

**Priority mux (combinational)**
- Opacity: bg_op = |bg_palette_idx_in[1:0]; sp_op = |spr_palette_idx_in[1:0].
- Lookup address sel:
  - !bg_op && !sp_op: 5'h00 (backdrop)
  - bg_op && !sp_op: {1'b0, bg_palette_idx_in}
  - !bg_op && sp_op: {1'b1, spr_palette_idx_in}
  - both opaque: spr_priority_in ? {1'b0, bg} : {1'b1, spr}
- sel passes through mirror() before the read. A pixel value 0 in any sub-palette always resolves to entry 0x00.

**Visible region**
- vis = (nes_x_in < 256) && (nes_y_in < 240).

**Output register**
- On a clock with pix_pulse_in=1: sys_palette_idx_out <= vis ? pal[sel] : pal[0].
- All other clocks: hold.

**Sprite-0 hit**
- Set: clock with pix_pulse_in=1 && vis && nes_x_in != 255 && bg_op && sp_op && spr_primary_in.
- Set does not depend on spr_priority_in.
- Clear: clock with pix_pulse_in=1 && nes_y_in == 261 && nes_x_in == 1.
- Once set, holds until cleared. Clear wins if set and clear coincide (they cannot overlap in a legal frame).

## Timing
- Reset values:
  - sys_palette_idx_out = 6'h00
  - spr0_hit_out = 0
  - all 32 palette entries = 6'h00
  - pal_d_out = 6'h00 on the first post-reset cycle
- Pixel latency: one pix_pulse_in period. The color sampled at pulse N is visible from the clock after pulse N until the clock after pulse N+1.
- Write/read collision: a pal_wr_in on the same clock as a render sample of the same entry gives the render the old value. The new value is seen from the next clock.
- Write and pix_pulse_in on the same clock both proceed; there is no stall and no arbitration.
- spr0_hit_out changes one clock after the qualifying pulse.
- Reset mid-frame: reset dominates all other events; every register takes its reset value on that clock.
- Inputs are assumed stable on the pix_pulse_in clock (ppu_bg drives registered outputs).

## Structure
- Shared PPU package holds:
  - NES_VIS_W = 256, NES_VIS_H = 240, NES_PRERENDER_Y = 261
  - function pal_mirror(addr[4:0]) -> addr[4:0]
- Sub-module: ppu_palette_ram.
  - 32x6 register file with reset.
  - One synchronous write port and two combinational read ports (CPU, render).
  - Mirroring is applied inside the sub-module.
- The priority mux, sprite-0 logic and output register live in ppu_pixel_out.

## Test plan
- Palette mirror: write 0x21 to addr 0x10 -> read addr 0x00 returns 0x21. Write 0x15 to 0x04 -> read 0x14 returns 0x15. Addr 0x11 stays independent.
- Priority: pal[0x05]=0x16, pal[0x12]=0x2A. Set bg=4'h5, spr=4'h2, spr_priority_in=0 -> out 0x2A after the pulse. Set spr_priority_in=1 -> 0x16. Set bg=4'h4 (transparent) -> 0x2A.
- Backdrop: bg=4'h8, spr=4'hC (both transparent), pal[0]=0x0F -> out 0x0F. At x=300, y=10 with opaque inputs -> out 0x0F.
- Sprite-0 hit:
  - both opaque with spr_primary_in=1 at x=100, y=50 -> spr0_hit_out=1 one clock later
  - it stays 1 through y=239
  - it clears at the pulse with y=261, x=1
  - the same condition at x=255 never sets it
- Collision: pal_wr_in to 0x05 on the same clock as a pulse selecting 0x05 -> output shows the old value; the next pulse shows the new value.
- Reset mid-frame with spr0_hit_out=1 and a non-zero palette -> all outputs 0 and pal_d_out = 0 for every address.

Source files
------------

// File: rtl/ppu_pixel_out_pkg.sv
// ppu_pixel_out_pkg: shared PPU screen geometry and palette address mirroring.
package ppu_pixel_out_pkg;
    localparam int NES_VIS_W = 256;
    localparam int NES_VIS_H = 240;
    localparam int NES_PRERENDER_Y = 261;
    // Sprite backdrop slots 0x10/0x14/0x18/0x1C alias the background ones.
    function automatic logic [4:0] pal_mirror(input logic [4:0] addr);
        return (addr[4] && addr[1:0] == 2'b00) ? {1'b0, addr[3:0]} : addr;
    endfunction
endpackage

// File: rtl/ppu_palette_ram.sv
// ppu_palette_ram: 32x6 palette register file, one mirrored write port and two mirrored combinational read ports.
// Ports: clk_in/rst_in; cpu_a, cpu_d, cpu_wr write port with cpu_q readback; ren_a/ren_q render read.
module ppu_palette_ram
    import ppu_pixel_out_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [4:0] cpu_a,
    input  logic [5:0] cpu_d,
    input  logic       cpu_wr,
    output logic [5:0] cpu_q,
    input  logic [4:0] ren_a,
    output logic [5:0] ren_q
);
    logic [5:0] mem [32];
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (cpu_wr) begin
            mem[pal_mirror(cpu_a)] <= cpu_d;
        end
    end
    assign cpu_q = mem[pal_mirror(cpu_a)];
    assign ren_q = mem[pal_mirror(ren_a)];
endmodule

// File: rtl/ppu_pixel_out.sv
// ppu_pixel_out: NES bg/sprite priority mux, palette lookup, registered pixel output and sticky sprite-0 hit.
// Ports: clk_in/rst_in; nes_x_in/nes_y_in/pix_pulse_in timing; bg/spr palette indices with
// spr_primary_in/spr_priority_in; pal_a_in/pal_d_in/pal_wr_in/pal_d_out CPU palette port;
// spr0_hit_out; sys_palette_idx_out.
module ppu_pixel_out
    import ppu_pixel_out_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [9:0] nes_x_in,
    input  logic [9:0] nes_y_in,
    input  logic       pix_pulse_in,
    input  logic [3:0] bg_palette_idx_in,
    input  logic [3:0] spr_palette_idx_in,
    input  logic       spr_primary_in,
    input  logic       spr_priority_in,
    input  logic [4:0] pal_a_in,
    input  logic [5:0] pal_d_in,
    input  logic       pal_wr_in,
    output logic [5:0] pal_d_out,
    output logic       spr0_hit_out,
    output logic [5:0] sys_palette_idx_out
);
    logic       bg_op, sp_op, vis, hit_set, hit_clr;
    logic [4:0] sel, ren_a;
    logic [5:0] ren_q;
    assign bg_op = |bg_palette_idx_in[1:0];
    assign sp_op = |spr_palette_idx_in[1:0];
    assign vis = (nes_x_in < 10'(NES_VIS_W)) && (nes_y_in < 10'(NES_VIS_H));
    always_comb begin
        sel = 5'h00;
        if (sp_op && !(bg_op && spr_priority_in)) sel = {1'b1, spr_palette_idx_in};
        else if (bg_op) sel = {1'b0, bg_palette_idx_in};
    end
    // Outside the visible area the backdrop colour is shown.
    assign ren_a = vis ? sel : 5'h00;
    assign hit_set = pix_pulse_in && vis && nes_x_in != 10'd255 && bg_op && sp_op && spr_primary_in;
    assign hit_clr = pix_pulse_in && nes_y_in == 10'(NES_PRERENDER_Y) && nes_x_in == 10'd1;
    ppu_palette_ram u_ram (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .cpu_a  (pal_a_in),
        .cpu_d  (pal_d_in),
        .cpu_wr (pal_wr_in),
        .cpu_q  (pal_d_out),
        .ren_a  (ren_a),
        .ren_q  (ren_q)
    );
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sys_palette_idx_out <= '0;
            spr0_hit_out <= 1'b0;
        end else begin
            if (pix_pulse_in) sys_palette_idx_out <= ren_q;
            spr0_hit_out <= hit_clr ? 1'b0 : (hit_set | spr0_hit_out);
        end
    end
endmodule
